// File: rtl/ex_stage_pipe_pkg.sv
// Shared encodings for the execute stage: ALU ops, next-PC selects, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ex_stage_pipe_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9,
      ALU_MUL  = 4'd10
   } alu_op_e;

   typedef enum logic [1:0] {
      NPC_PC4  = 2'd0,
      NPC_BR   = 2'd1,
      NPC_JMP  = 2'd2,
      NPC_JALR = 2'd3
   } npc_op_e;

   // Jump offset source select.
   localparam logic NPCO_ALU = 1'b1;
   localparam logic NPCO_EXT = 1'b0;

   typedef enum logic {
      EX_IDLE = 1'b0,
      EX_MUL  = 1'b1
   } ex_state_e;

endpackage

// File: rtl/ex_mul_iter.sv
// Iterative shift-add multiplier, low XLEN bits of A*B.
// Latency: exactly XLEN step cycles after start; no early exit.
// Backpressure: none; the parent stalls by withholding step/start.
module ex_mul_iter #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            step,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            done,
   output logic [XLEN-1:0] p
);
   localparam int CW = $clog2(XLEN);

   logic [XLEN-1:0] a_r;
   logic [XLEN-1:0] b_r;
   logic [XLEN-1:0] acc;
   logic [CW-1:0]   cnt;
   logic [XLEN-1:0] acc_nxt;

   assign acc_nxt = acc + (b_r[0] ? a_r : '0);
   // The product is taken from acc_nxt so the final iteration lands in the
   // parent's output register on the same edge it completes.
   assign p       = acc_nxt;
   assign done    = step && (cnt == CW'(XLEN - 1));

   // Operand load on start, one shift-add iteration per step.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_r <= '0;
         b_r <= '0;
         acc <= '0;
         cnt <= '0;
      end else if (start) begin
         a_r <= a;
         b_r <= b;
         acc <= '0;
         cnt <= '0;
      end else if (step) begin
         acc <= acc_nxt;
         a_r <= a_r << 1;
         b_r <= b_r >> 1;
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/ex_stage_pipe.sv
// Execute stage: ALU, branch/jump next-PC and iterative multiplier, registered outputs.
// Latency: 1 cycle for ALU ops, XLEN cycles for MUL.
// Backpressure: in_ready drops while multiplying or while a held result is not consumed.
module ex_stage_pipe
   import ex_stage_pipe_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter bit MUL_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      alu_op,
   input  logic [1:0]      npc_op,
   input  logic            npco_sel,
   input  logic [XLEN-1:0] aluA,
   input  logic [XLEN-1:0] aluB,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] ext,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] aluC,
   output logic [XLEN-1:0] npc,
   output logic [XLEN-1:0] pc4,
   output logic            redirect,
   output logic            busy
);
   localparam int SHW = $clog2(XLEN);

   ex_state_e       state, state_nxt;
   alu_op_e         op;
   logic            is_mul, accept, alu_accept, mul_start, mul_done;
   logic [SHW-1:0]  shamt;
   logic [XLEN-1:0] alu_res, alu_npc, alu_pc4, mul_p, mul_npc, mul_pc4;
   logic            flag;

   // Context captured with a MUL so its next-PC can be formed when it finishes.
   npc_op_e         m_nop;
   logic            m_sel;
   logic [XLEN-1:0] m_pc, m_ext;

   function automatic logic [XLEN-1:0] next_pc(input npc_op_e nop, input logic f,
                                               input logic sel, input logic [XLEN-1:0] p,
                                               input logic [XLEN-1:0] e, input logic [XLEN-1:0] r);
      logic [XLEN-1:0] off;
      off = (sel == NPCO_ALU) ? r : e;
      case (nop)
         NPC_BR:   return f ? (p + e) : (p + XLEN'(4));
         NPC_JMP:  return p + off;
         NPC_JALR: return {r[XLEN-1:1], 1'b0};
         default:  return p + XLEN'(4);
      endcase
   endfunction

   assign op         = alu_op_e'(alu_op);
   assign is_mul     = MUL_EN && (op == ALU_MUL);
   assign shamt      = aluB[SHW-1:0];
   assign in_ready   = (state == EX_IDLE) && (!out_valid || out_ready) && !flush;
   assign accept     = in_valid && in_ready;
   assign alu_accept = accept && !is_mul;
   assign mul_start  = accept && is_mul;
   assign busy       = (state == EX_MUL);

   // Single-cycle ALU; MUL with the multiplier disabled and unused codes fall back to ADD.
   always_comb begin
      alu_res = '0;
      case (op)
         ALU_SUB:  alu_res = aluA - aluB;
         ALU_AND:  alu_res = aluA & aluB;
         ALU_OR:   alu_res = aluA | aluB;
         ALU_XOR:  alu_res = aluA ^ aluB;
         ALU_SLL:  alu_res = aluA << shamt;
         ALU_SRL:  alu_res = aluA >> shamt;
         ALU_SRA:  alu_res = $unsigned($signed(aluA) >>> shamt);
         ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(aluA) < $signed(aluB))};
         ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (aluA < aluB)};
         default:  alu_res = aluA + aluB;
      endcase
   end

   // Branch condition derived from the compare-style ops only.
   always_comb begin
      flag = 1'b0;
      case (op)
         ALU_SUB:  flag = (alu_res == '0);
         ALU_SLT,
         ALU_SLTU: flag = alu_res[0];
         default:  flag = 1'b0;
      endcase
   end

   assign alu_npc = next_pc(npc_op_e'(npc_op), flag, npco_sel, pc, ext, alu_res);
   assign alu_pc4 = pc + XLEN'(4);
   assign mul_npc = next_pc(m_nop, 1'b0, m_sel, m_pc, m_ext, mul_p);
   assign mul_pc4 = m_pc + XLEN'(4);

   ex_mul_iter #(.XLEN(XLEN)) u_mul (
      .clk   (clk),
      .rst   (rst),
      .start (mul_start),
      .step  (busy),
      .a     (aluA),
      .b     (aluB),
      .done  (mul_done),
      .p     (mul_p)
   );

   // Latch the MUL's next-PC context on accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_nop <= NPC_PC4;
         m_sel <= 1'b0;
         m_pc  <= '0;
         m_ext <= '0;
      end else if (mul_start) begin
         m_nop <= npc_op_e'(npc_op);
         m_sel <= npco_sel;
         m_pc  <= pc;
         m_ext <= ext;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= EX_IDLE;
      else     state <= state_nxt;
   end

   // FSM next state: flush aborts an in-flight multiply.
   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = EX_IDLE;
      end else begin
         case (state)
            EX_IDLE: if (mul_start) state_nxt = EX_MUL;
            EX_MUL:  if (mul_done)  state_nxt = EX_IDLE;
            default: state_nxt = EX_IDLE;
         endcase
      end
   end

   // Result registers: load on ALU accept or MUL completion, drop when consumed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         aluC      <= '0;
         npc       <= '0;
         pc4       <= '0;
         redirect  <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
         redirect  <= 1'b0;
      end else if (alu_accept) begin
         out_valid <= 1'b1;
         aluC      <= alu_res;
         npc       <= alu_npc;
         pc4       <= alu_pc4;
         redirect  <= (alu_npc != alu_pc4);
      end else if (mul_done) begin
         out_valid <= 1'b1;
         aluC      <= mul_p;
         npc       <= mul_npc;
         pc4       <= mul_pc4;
         redirect  <= (mul_npc != mul_pc4);
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ex_stage_pipe.sv
module tb_ex_stage_pipe;
   import ex_stage_pipe_pkg::*;

   localparam int XLEN = 32;

   logic              clk = 1'b0;
   logic              rst, flush, in_valid, in_ready, npco_sel;
   logic              out_valid, out_ready, redirect, busy;
   logic [3:0]        alu_op;
   logic [1:0]        npc_op;
   logic [XLEN-1:0]   aluA, aluB, pc, ext, aluC, npc, pc4;

   typedef struct packed {
      logic [31:0] c;
      logic [31:0] n;
      logic [31:0] p4;
      logic        r;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;
   bit   bp_rand = 1'b0;

   always #5 clk = ~clk;

   ex_stage_pipe #(.XLEN(XLEN), .MUL_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .alu_op(alu_op), .npc_op(npc_op), .npco_sel(npco_sel), .aluA(aluA), .aluB(aluB),
      .pc(pc), .ext(ext), .out_valid(out_valid), .out_ready(out_ready), .aluC(aluC),
      .npc(npc), .pc4(pc4), .redirect(redirect), .busy(busy)
   );

   // Reference: plain arithmetic from the op definitions.
   function automatic exp_t model(input logic [3:0] op, input logic [1:0] nop, input logic sel,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] p, input logic [31:0] e);
      logic [31:0] r;
      logic [63:0] prod;
      logic [4:0]  sh;
      logic        taken;
      exp_t        x;
      sh = b[4:0];
      case (op)
         ALU_SUB:  r = a - b;
         ALU_AND:  r = a & b;
         ALU_OR:   r = a | b;
         ALU_XOR:  r = a ^ b;
         ALU_SLL:  r = a << sh;
         ALU_SRL:  r = a >> sh;
         ALU_SRA:  r = $unsigned($signed(a) >>> sh);
         ALU_SLT:  r = {31'b0, ($signed(a) < $signed(b))};
         ALU_SLTU: r = {31'b0, (a < b)};
         ALU_MUL:  begin prod = {32'b0, a} * {32'b0, b}; r = prod[31:0]; end
         default:  r = a + b;
      endcase
      taken = ((op == ALU_SUB) && (r == 32'd0)) || (((op == ALU_SLT) || (op == ALU_SLTU)) && r[0]);
      x.c  = r;
      x.p4 = p + 32'd4;
      case (nop)
         NPC_BR:   x.n = taken ? p + e : p + 32'd4;
         NPC_JMP:  x.n = p + (sel ? r : e);
         NPC_JALR: x.n = r & 32'hFFFF_FFFE;
         default:  x.n = p + 32'd4;
      endcase
      x.r = (x.n != x.p4);
      return x;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one instruction (from posedge+1) until accepted; expected result queued at accept.
   task automatic issue(input logic [3:0] op, input logic [1:0] nop, input logic sel,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] p, input logic [31:0] e);
      int t;
      alu_op = op; npc_op = nop; npco_sel = sel; aluA = a; aluB = b; pc = p; ext = e;
      in_valid = 1'b1;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!in_ready && t < 500);
      if (!in_ready) begin
         n_cmp++; n_err++;
         $display("FAIL issue_timeout: in_ready stuck low, needed 1");
      end else begin
         sb.push_back(model(op, nop, sel, a, b, p, e));
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Random MEM-stage back-pressure when enabled.
   always @(posedge clk) begin
      #1;
      if (bp_rand) out_ready = ($urandom_range(0, 3) != 0);
   end

   // Monitor: every consumed result is checked against the head of the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (sb.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_result: aluC %h with empty scoreboard", aluC);
         end else begin
            e = sb.pop_front();
            chk("aluC", aluC, e.c);
            chk("npc", npc, e.n);
            chk("pc4", pc4, e.p4);
            chk("redirect", {31'b0, redirect}, {31'b0, e.r});
         end
      end
   end

   initial begin
      exp_t xexp;
      int   cnt;
      bit   saw;
      logic [3:0]  rop;
      logic [31:0] ra, rb;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      alu_op = '0; npc_op = '0; npco_sel = 1'b0; aluA = '0; aluB = '0; pc = '0; ext = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_aluC", aluC, 32'd0);
      chk("rst_npc", npc, 32'd0);
      chk("rst_pc4", pc4, 32'd0);
      chk("rst_redirect", {31'b0, redirect}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk); #1;

      // ADD with one-cycle latency
      issue(ALU_ADD, NPC_PC4, 1'b0, 32'd5, 32'd7, 32'h100, 32'd0);
      @(negedge clk);
      chk("lat1_out_valid", {31'b0, out_valid}, 32'd1);
      @(posedge clk); #1;
      // Branch taken / not taken, JALR, JMP
      issue(ALU_SUB, NPC_BR, 1'b0, 32'd9, 32'd9, 32'h200, 32'h40);
      issue(ALU_SUB, NPC_BR, 1'b0, 32'd9, 32'd8, 32'h200, 32'h40);
      issue(ALU_ADD, NPC_JALR, 1'b1, 32'h1003, 32'd0, 32'h300, 32'd0);
      issue(ALU_ADD, NPC_JMP, 1'b0, 32'd1, 32'd2, 32'h20, 32'hFFFF_FFF8);
      issue(ALU_SLT, NPC_BR, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h400, 32'h10);

      // MUL latency and busy window
      issue(ALU_MUL, NPC_PC4, 1'b0, 32'hFFFF_FFFF, 32'd3, 32'h500, 32'd0);
      cnt = 0; saw = 1'b0;
      while (cnt < 100) begin
         @(negedge clk);
         if (out_valid) break;
         if (!busy || in_ready) saw = 1'b1;
         cnt++;
      end
      chk("mul_latency", cnt, 32'd32);
      chk("mul_busy_stall", {31'b0, saw}, 32'd0);
      @(posedge clk); #1;

      // Back-pressure hold, then back-to-back results
      out_ready = 1'b0;
      xexp = model(ALU_XOR, NPC_PC4, 1'b0, 32'hA5A5_0000, 32'h0F0F_1234, 32'h600, 32'd0);
      issue(ALU_XOR, NPC_PC4, 1'b0, 32'hA5A5_0000, 32'h0F0F_1234, 32'h600, 32'd0);
      alu_op = ALU_OR; npc_op = NPC_PC4; aluA = 32'h0000_00F0; aluB = 32'h0000_000F; pc = 32'h604;
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
         chk("bp_hold_aluC", aluC, xexp.c);
         chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("b2b_in_ready", {31'b0, in_ready}, 32'd1);
      sb.push_back(model(ALU_OR, NPC_PC4, 1'b0, 32'h0000_00F0, 32'h0000_000F, 32'h604, 32'd0));
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("b2b_no_bubble", {31'b0, out_valid}, 32'd1);
      @(posedge clk); #1;

      // Flush during MUL iteration 10
      issue(ALU_MUL, NPC_PC4, 1'b0, 32'd1234, 32'd5678, 32'h700, 32'd0);
      repeat (9) @(posedge clk);
      #1 flush = 1'b1;
      @(negedge clk);
      chk("flush_in_ready", {31'b0, in_ready}, 32'd0);
      @(posedge clk); #1;
      flush = 1'b0;
      void'(sb.pop_back());
      @(negedge clk);
      chk("flush_busy", {31'b0, busy}, 32'd0);
      chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
      chk("flush_idle_ready", {31'b0, in_ready}, 32'd1);
      saw = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) saw = 1'b1;
      end
      chk("flush_no_result", {31'b0, saw}, 32'd0);
      @(posedge clk); #1;

      // Asynchronous reset mid-MUL
      issue(ALU_MUL, NPC_PC4, 1'b0, 32'd77, 32'd99, 32'h800, 32'd0);
      repeat (5) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("arst_busy", {31'b0, busy}, 32'd0);
      chk("arst_aluC", aluC, 32'd0);
      chk("arst_npc", npc, 32'd0);
      chk("arst_pc4", pc4, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      void'(sb.pop_back());
      issue(ALU_ADD, NPC_PC4, 1'b0, 32'd2, 32'd3, 32'h900, 32'd0);

      // Randomized traffic with random back-pressure
      bp_rand = 1'b1;
      for (int i = 0; i < 200; i++) begin
         rop = 4'($urandom_range(0, 10));
         ra  = $urandom;
         case ($urandom_range(0, 3))
            0: rb = $urandom;
            1: rb = 32'($urandom_range(0, 40));
            2: rb = ra;
            default: rb = ra + 32'd1;
         endcase
         issue(rop, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ra, rb,
               $urandom & 32'hFFFF_FFFC, 32'($urandom_range(0, 4095)) - 32'd2048);
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      bp_rand = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b1;
      cnt = 0;
      while (sb.size() != 0 && cnt < 200) begin
         @(negedge clk);
         cnt++;
      end
      chk("drain_empty", sb.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
